// File: rtl/kgp_branch_pkg.sv
// Shared opcode/condition encodings, sequencer state type and the
// branch-condition evaluator used by branch_sequencer.
package kgp_branch_pkg;

  localparam logic [2:0] OPC_BRANCH = 3'b011;
  localparam logic [2:0] OPC_JUMP   = 3'b100;

  localparam logic [3:0] FC_JMP  = 4'd0;
  localparam logic [3:0] FC_Z    = 4'd1;
  localparam logic [3:0] FC_NZ   = 4'd2;
  localparam logic [3:0] FC_C    = 4'd3;
  localparam logic [3:0] FC_NC   = 4'd4;
  localparam logic [3:0] FC_S    = 4'd5;
  localparam logic [3:0] FC_NS   = 4'd6;
  localparam logic [3:0] FC_V    = 4'd7;
  localparam logic [3:0] FC_NV   = 4'd8;
  localparam logic [3:0] FC_CALL = 4'd9;
  localparam logic [3:0] FC_RET  = 4'd10;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } seq_state_t;

  // Branch-group condition; fcodes 11-15 are reserved and never taken.
  function automatic logic cond_taken(input logic [3:0] fc,
                                      input logic c, input logic z,
                                      input logic v, input logic s);
    logic t;
    t = 1'b0;
    case (fc)
      FC_JMP:  t = 1'b1;
      FC_Z:    t = z;
      FC_NZ:   t = ~z;
      FC_C:    t = c;
      FC_NC:   t = ~c;
      FC_S:    t = s;
      FC_NS:   t = ~s;
      FC_V:    t = v;
      FC_NV:   t = ~v;
      FC_CALL: t = 1'b1;
      FC_RET:  t = 1'b1;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. A push onto a full stack overwrites the
// oldest entry and leaves the count saturated. Entry storage is not reset.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     push_data,
  output logic [W-1:0]     top,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wp_q, wp_d;
  logic [PTR_W-1:0] wp_prev;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign wp_prev = wp_q - PTR_W'(1);
  assign top     = mem_q[wp_prev];
  assign count   = cnt_q;
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);

  // Pointer and occupancy update; with a full stack wp already addresses the oldest slot.
  always_comb begin
    wp_d  = wp_q;
    cnt_d = cnt_q;
    if (push) begin
      wp_d = wp_q + PTR_W'(1);
      if (!full) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !empty) begin
      wp_d  = wp_prev;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Pointer/count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage, deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= push_data;
  end

endmodule

// File: rtl/branch_sequencer.sv
// Program-counter owner and branch sequencer: decodes branch/jump ops against
// ALU flags, redirects the PC, raises a one-cycle flush and manages the RAS.
//
//   state    | meaning
//   ST_RUN   | normal fetch; evaluates a valid op each cycle
//   ST_FLUSH | redirect just taken; flush=1, incoming op ignored
//   ST_HALT  | RAS underflow; everything frozen until reset
module branch_sequencer
  import kgp_branch_pkg::*;
#(
  parameter int              PC_W      = 8,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall,
  input  logic                         instr_valid,
  input  logic [2:0]                   opcode,
  input  logic [3:0]                   fcode,
  input  logic [PC_W-1:0]              branch_addr,
  input  logic                         carry_flag,
  input  logic                         zero_flag,
  input  logic                         overflow_flag,
  input  logic                         sign_flag,
  output logic [PC_W-1:0]              pc,
  output logic                         flush,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ras_underflow,
  output logic                         halted
);

  seq_state_t      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            flush_q, flush_d;
  logic            ras_ovf_q, ras_ovf_d;
  logic            ras_unf_q, ras_unf_d;
  logic            halted_q, halted_d;

  logic            is_branch, is_jump, is_call, is_ret, taken;
  logic [PC_W-1:0] pc_inc;
  logic            ras_push, ras_pop, ras_full, ras_empty;
  logic [PC_W-1:0] ras_top;

  assign pc_inc = pc_q + PC_W'(1);

  // Condition decode for the op presented this cycle.
  always_comb begin
    is_branch = (opcode == OPC_BRANCH);
    is_jump   = (opcode == OPC_JUMP);
    is_call   = is_branch && (fcode == FC_CALL);
    is_ret    = is_branch && (fcode == FC_RET);
    taken     = is_jump ||
                (is_branch && cond_taken(fcode, carry_flag, zero_flag,
                                         overflow_flag, sign_flag));
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc),
    .top       (ras_top),
    .count     (ras_count),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  // Sequencer next-state: stall freezes every register including the RAS.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    flush_d   = flush_q;
    ras_ovf_d = ras_ovf_q;
    ras_unf_d = ras_unf_q;
    halted_d  = halted_q;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    if (!stall) begin
      case (state_q)
        ST_RUN: begin
          pc_d    = pc_inc;
          flush_d = 1'b0;
          if (instr_valid && taken) begin
            if (is_ret && ras_empty) begin
              // Nothing to return to: stop with the PC where it is.
              pc_d      = pc_q;
              ras_unf_d = 1'b1;
              halted_d  = 1'b1;
              state_d   = ST_HALT;
            end else begin
              pc_d     = is_ret ? ras_top : branch_addr;
              flush_d  = 1'b1;
              state_d  = ST_FLUSH;
              ras_push = is_call;
              ras_pop  = is_ret;
              if (is_call && ras_full) ras_ovf_d = 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          pc_d    = pc_inc;
          flush_d = 1'b0;
          state_d = ST_RUN;
        end
        ST_HALT: begin
          flush_d = 1'b0;
        end
        default: begin
          state_d = ST_RUN;
          flush_d = 1'b0;
        end
      endcase
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_PC;
      flush_q   <= 1'b0;
      ras_ovf_q <= 1'b0;
      ras_unf_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      flush_q   <= flush_d;
      ras_ovf_q <= ras_ovf_d;
      ras_unf_q <= ras_unf_d;
      halted_q  <= halted_d;
    end
  end

  assign pc            = pc_q;
  assign flush         = flush_q;
  assign ras_overflow  = ras_ovf_q;
  assign ras_underflow = ras_unf_q;
  assign halted        = halted_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: reset, condition decode, call/return,
// RAS overflow/underflow, halt, stall and PC wrap.
module tb_branch_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall;
  logic       instr_valid;
  logic [2:0] opcode;
  logic [3:0] fcode;
  logic [7:0] branch_addr;
  logic       carry_flag, zero_flag, overflow_flag, sign_flag;
  logic [7:0] pc;
  logic       flush;
  logic [2:0] ras_count;
  logic       ras_overflow, ras_underflow, halted;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_sequencer #(.PC_W(8), .RAS_DEPTH(4), .RESET_PC(8'h00)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .instr_valid   (instr_valid),
    .opcode        (opcode),
    .fcode         (fcode),
    .branch_addr   (branch_addr),
    .carry_flag    (carry_flag),
    .zero_flag     (zero_flag),
    .overflow_flag (overflow_flag),
    .sign_flag     (sign_flag),
    .pc            (pc),
    .flush         (flush),
    .ras_count     (ras_count),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow),
    .halted        (halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    instr_valid   = 1'b0;
    opcode        = 3'b000;
    fcode         = 4'd0;
    branch_addr   = 8'h00;
    carry_flag    = 1'b0;
    zero_flag     = 1'b0;
    overflow_flag = 1'b0;
    sign_flag     = 1'b0;
  endtask

  // Jump to a-1; the flush cycle then steps the PC onto a, leaving the FSM in RUN.
  task automatic goto_pc(input logic [7:0] a);
    idle();
    instr_valid = 1'b1;
    opcode      = 3'b100;
    branch_addr = a - 8'd1;
    tick();
    idle();
    tick();
  endtask

  task automatic do_reset();
    idle();
    stall = 1'b0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle();
    stall = 1'b0;
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({pc, flush, ras_count, ras_overflow, ras_underflow, halted} !==
        {8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state pc=%h flush=%b cnt=%0d ovf=%b unf=%b halt=%b required 00/0/0/0/0/0",
               pc, flush, ras_count, ras_overflow, ras_underflow, halted);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (pc !== 8'h01) begin
      n_err++;
      $display("FAIL reset_release pc=%h required 01", pc);
    end
  endtask

  task automatic test_reset_in_flush();
    instr_valid = 1'b1;
    opcode      = 3'b100;
    branch_addr = 8'h40;
    tick();
    n_cmp++;
    if ({pc, flush} !== {8'h40, 1'b1}) begin
      n_err++;
      $display("FAIL rif_redirect pc=%h flush=%b required 40/1", pc, flush);
    end
    idle();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({pc, flush} !== {8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL rif_async pc=%h flush=%b required 00/0", pc, flush);
    end
    #2;
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({pc, flush} !== {8'h01, 1'b0}) begin
      n_err++;
      $display("FAIL rif_resume pc=%h flush=%b required 01/0", pc, flush);
    end
  endtask

  task automatic test_cond_branch();
    goto_pc(8'h10);
    instr_valid = 1'b1;
    opcode      = 3'b011;
    fcode       = 4'd1;
    zero_flag   = 1'b1;
    branch_addr = 8'h40;
    tick();
    n_cmp++;
    if ({pc, flush} !== {8'h40, 1'b1}) begin
      n_err++;
      $display("FAIL bz_taken pc=%h flush=%b required 40/1", pc, flush);
    end
    idle();
    tick();
    n_cmp++;
    if ({pc, flush} !== {8'h41, 1'b0}) begin
      n_err++;
      $display("FAIL bz_after pc=%h flush=%b required 41/0", pc, flush);
    end
    goto_pc(8'h10);
    instr_valid = 1'b1;
    opcode      = 3'b011;
    fcode       = 4'd1;
    zero_flag   = 1'b0;
    branch_addr = 8'h40;
    tick();
    n_cmp++;
    if ({pc, flush} !== {8'h11, 1'b0}) begin
      n_err++;
      $display("FAIL bz_not_taken pc=%h flush=%b required 11/0", pc, flush);
    end
    idle();
  endtask

  // Each entry: {opcode[2:0], fcode[3:0], C, Z, V, S, taken}
  task automatic test_cond_table();
    logic [11:0] vec [13];
    logic [11:0] v;
    logic [7:0]  exp_pc;
    vec = '{
      {3'b011, 4'd0,  4'b0000, 1'b1},
      {3'b011, 4'd1,  4'b0000, 1'b0},
      {3'b011, 4'd2,  4'b0000, 1'b1},
      {3'b011, 4'd3,  4'b1000, 1'b1},
      {3'b011, 4'd4,  4'b1000, 1'b0},
      {3'b011, 4'd5,  4'b0000, 1'b0},
      {3'b011, 4'd6,  4'b0000, 1'b1},
      {3'b011, 4'd7,  4'b0010, 1'b1},
      {3'b011, 4'd8,  4'b0000, 1'b1},
      {3'b011, 4'd8,  4'b0010, 1'b0},
      {3'b011, 4'd11, 4'b1111, 1'b0},
      {3'b011, 4'd15, 4'b1111, 1'b0},
      {3'b010, 4'd0,  4'b1111, 1'b0}
    };
    for (int i = 0; i < 13; i++) begin
      v = vec[i];
      goto_pc(8'h30);
      instr_valid   = 1'b1;
      opcode        = v[11:9];
      fcode         = v[8:5];
      carry_flag    = v[4];
      zero_flag     = v[3];
      overflow_flag = v[2];
      sign_flag     = v[1];
      branch_addr   = 8'h50;
      tick();
      exp_pc = v[0] ? 8'h50 : 8'h31;
      n_cmp++;
      if ({pc, flush} !== {exp_pc, v[0]}) begin
        n_err++;
        $display("FAIL cond_vec%0d pc=%h flush=%b required %h/%b", i, pc, flush, exp_pc, v[0]);
      end
      idle();
      tick();
    end
  endtask

  task automatic test_call_return();
    goto_pc(8'h20);
    instr_valid = 1'b1;
    opcode      = 3'b011;
    fcode       = 4'd9;
    branch_addr = 8'h80;
    tick();
    n_cmp++;
    if ({pc, flush, ras_count} !== {8'h80, 1'b1, 3'd1}) begin
      n_err++;
      $display("FAIL call pc=%h flush=%b cnt=%0d required 80/1/1", pc, flush, ras_count);
    end
    idle();
    tick();
    tick();
    instr_valid = 1'b1;
    opcode      = 3'b011;
    fcode       = 4'd10;
    branch_addr = 8'hEE;
    tick();
    n_cmp++;
    if ({pc, flush, ras_count} !== {8'h21, 1'b1, 3'd0}) begin
      n_err++;
      $display("FAIL return pc=%h flush=%b cnt=%0d required 21/1/0", pc, flush, ras_count);
    end
    idle();
    tick();
  endtask

  task automatic test_overflow_underflow();
    logic [7:0] exp_ret [4];
    exp_ret = '{8'h06, 8'h05, 8'h04, 8'h03};
    goto_pc(8'h01);
    for (int i = 1; i <= 5; i++) begin
      instr_valid = 1'b1;
      opcode      = 3'b011;
      fcode       = 4'd9;
      branch_addr = 8'(i);
      tick();
      idle();
      tick();
    end
    n_cmp++;
    if ({pc, ras_count, ras_overflow, ras_underflow} !== {8'h06, 3'd4, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL ovf_calls pc=%h cnt=%0d ovf=%b unf=%b required 06/4/1/0",
               pc, ras_count, ras_overflow, ras_underflow);
    end
    for (int k = 0; k < 4; k++) begin
      instr_valid = 1'b1;
      opcode      = 3'b011;
      fcode       = 4'd10;
      tick();
      n_cmp++;
      if ({pc, flush} !== {exp_ret[k], 1'b1}) begin
        n_err++;
        $display("FAIL ovf_ret%0d pc=%h flush=%b required %h/1", k, pc, flush, exp_ret[k]);
      end
      idle();
      tick();
    end
    n_cmp++;
    if ({pc, ras_count} !== {8'h04, 3'd0}) begin
      n_err++;
      $display("FAIL ovf_drained pc=%h cnt=%0d required 04/0", pc, ras_count);
    end
    instr_valid = 1'b1;
    opcode      = 3'b011;
    fcode       = 4'd10;
    tick();
    n_cmp++;
    if ({pc, flush, ras_underflow, halted} !== {8'h04, 1'b0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL unf_after_ovf pc=%h flush=%b unf=%b halt=%b required 04/0/1/1",
               pc, flush, ras_underflow, halted);
    end
    idle();
  endtask

  task automatic test_halt();
    do_reset();
    instr_valid = 1'b1;
    opcode      = 3'b011;
    fcode       = 4'd10;
    branch_addr = 8'h77;
    tick();
    n_cmp++;
    if ({pc, flush, ras_underflow, halted, ras_overflow} !== {8'h00, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL halt_entry pc=%h flush=%b unf=%b halt=%b ovf=%b required 00/0/1/1/0",
               pc, flush, ras_underflow, halted, ras_overflow);
    end
    for (int i = 0; i < 10; i++) begin
      instr_valid = 1'b1;
      opcode      = 3'b100;
      branch_addr = 8'hA0 + 8'(i);
      stall       = i[0];
      tick();
      n_cmp++;
      if ({pc, flush, halted, ras_count} !== {8'h00, 1'b0, 1'b1, 3'd0}) begin
        n_err++;
        $display("FAIL halt_hold%0d pc=%h flush=%b halt=%b cnt=%0d required 00/0/1/0",
                 i, pc, flush, halted, ras_count);
      end
    end
    do_reset();
    tick();
    n_cmp++;
    if ({pc, halted, ras_underflow} !== {8'h01, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL halt_reset pc=%h halt=%b unf=%b required 01/0/0", pc, halted, ras_underflow);
    end
  endtask

  task automatic test_stall();
    goto_pc(8'h60);
    instr_valid = 1'b1;
    opcode      = 3'b100;
    branch_addr = 8'h90;
    stall       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({pc, flush} !== {8'h60, 1'b0}) begin
        n_err++;
        $display("FAIL stall_run%0d pc=%h flush=%b required 60/0", i, pc, flush);
      end
    end
    stall = 1'b0;
    tick();
    n_cmp++;
    if ({pc, flush} !== {8'h90, 1'b1}) begin
      n_err++;
      $display("FAIL stall_release pc=%h flush=%b required 90/1", pc, flush);
    end
    idle();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if ({pc, flush} !== {8'h90, 1'b1}) begin
        n_err++;
        $display("FAIL stall_flush%0d pc=%h flush=%b required 90/1", i, pc, flush);
      end
    end
    stall = 1'b0;
    tick();
    n_cmp++;
    if ({pc, flush} !== {8'h91, 1'b0}) begin
      n_err++;
      $display("FAIL stall_flush_exit pc=%h flush=%b required 91/0", pc, flush);
    end
  endtask

  task automatic test_wrap();
    goto_pc(8'hFF);
    instr_valid = 1'b1;
    opcode      = 3'b000;
    tick();
    n_cmp++;
    if ({pc, flush} !== {8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL wrap_inc pc=%h flush=%b required 00/0", pc, flush);
    end
    goto_pc(8'hFF);
    instr_valid = 1'b1;
    opcode      = 3'b011;
    fcode       = 4'd9;
    branch_addr = 8'h10;
    tick();
    idle();
    tick();
    instr_valid = 1'b1;
    opcode      = 3'b011;
    fcode       = 4'd10;
    tick();
    n_cmp++;
    if ({pc, flush, ras_count} !== {8'h00, 1'b1, 3'd0}) begin
      n_err++;
      $display("FAIL wrap_call_ret pc=%h flush=%b cnt=%0d required 00/1/0", pc, flush, ras_count);
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_in_flush();
    test_cond_branch();
    test_cond_table();
    test_call_return();
    test_overflow_underflow();
    test_halt();
    test_stall();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
